tut4_verilog_sort_valrdy_sorter: RTL and testbench

Three-stage pipelined sorter: accepts four unsigned p_nbits values per transaction over a val/rdy interface and emits them sorted ascending over a val/rdy interface. Built from a five-comparator sorting network of min/max units, with registers between network layers. Sits directly downstream of the min/max unit, which it consumes as its only compute primitive. Per-stage flow control supports full throughput and back-pressure.

---
 rtl/tut4_verilog_sort_pkg.sv | 10 +
 rtl/tut4_verilog_sort_MinMaxUnit.sv | 21 ++
 rtl/tut4_verilog_sort_PipeReg.sv | 29 ++
 rtl/tut4_verilog_sort_valrdy_sorter.sv | 119 +++++++++++
 tb/tb_tut4_verilog_sort_valrdy_sorter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tut4_verilog_sort_pkg.sv
// Shared sizing constants for the four-element pipelined sorter.
package tut4_verilog_sort_pkg;

   // Registered layers in the sorting network.
   localparam int SORT_NSTAGES = 3;

   // Elements carried by one transaction.
   localparam int SORT_NELEMS  = 4;

endpackage

// File: rtl/tut4_verilog_sort_MinMaxUnit.sv
// Unsigned two-input min/max: the only compute primitive of the sorter.
module tut4_verilog_sort_MinMaxUnit #(
   parameter int p_nbits = 8
) (
   input  logic [p_nbits-1:0] in0,
   input  logic [p_nbits-1:0] in1,
   output logic [p_nbits-1:0] out_min,
   output logic [p_nbits-1:0] out_max
);

   // Swap only when in0 is strictly larger; on a tie both outputs are equal anyway.
   always_comb begin
      out_min = in0;
      out_max = in1;
      if (in0 > in1) begin
         out_min = in1;
         out_max = in0;
      end
   end

endmodule

// File: rtl/tut4_verilog_sort_PipeReg.sv
// Enable-plus-reset register used for both data and valid bits of each stage.
module tut4_verilog_sort_PipeReg #(
   parameter int p_nbits = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [p_nbits-1:0] d,
   output logic [p_nbits-1:0] q
);

   logic [p_nbits-1:0] q_q;
   logic [p_nbits-1:0] q_d;

   // Next value: load d when enabled, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (en) q_d = d;
   end

   // State register with synchronous clear to zero.
   always_ff @(posedge clk) begin
      if (reset) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/tut4_verilog_sort_valrdy_sorter.sv
// Three-stage pipelined four-element sorter with val/rdy on both sides.
//
// Network: layer 1 sorts pairs (in0,in1) and (in2,in3); layer 2 merges the
// mins and the maxes, fixing the global min (e) and max (h); layer 3 orders
// the two middle values. Each layer result is registered in its own stage.
//
// Integration note: in_rdy is a combinational function of out_rdy through
// the rdy chain (rdy3 -> rdy2 -> rdy1). This lets an empty stage absorb data
// while downstream is stalled and gives full throughput, at the cost of a
// comb path from out_rdy to in_rdy that the integrator must close timing on
// and must not loop back combinationally.
//
// During the reset cycle out_val/out0..out3 are forced to 0 and in_rdy to 1,
// so no stale result is ever offered and the upstream sees the post-reset
// interface immediately.
module tut4_verilog_sort_valrdy_sorter
   import tut4_verilog_sort_pkg::*;
#(
   parameter int p_nbits = 8
) (
   input  logic               clk,
   input  logic               reset,

   input  logic               in_val,
   output logic               in_rdy,
   input  logic [p_nbits-1:0] in0,
   input  logic [p_nbits-1:0] in1,
   input  logic [p_nbits-1:0] in2,
   input  logic [p_nbits-1:0] in3,

   output logic               out_val,
   input  logic               out_rdy,
   output logic [p_nbits-1:0] out0,
   output logic [p_nbits-1:0] out1,
   output logic [p_nbits-1:0] out2,
   output logic [p_nbits-1:0] out3
);

   localparam int DW = SORT_NELEMS * p_nbits;

   // vld_pipe[0] is the upstream valid; vld_pipe[k] is the valid of stage k.
   logic [SORT_NSTAGES:0]   vld_pipe;
   logic [SORT_NSTAGES:1]   stg_rdy;
   logic [SORT_NSTAGES:1]   dat_en;
   logic                    rdy1, rdy2, rdy3;

   // Per-layer network values and stage registers, element 0 first.
   logic [SORT_NELEMS-1:0][p_nbits-1:0] l1, s1;
   logic [SORT_NELEMS-1:0][p_nbits-1:0] l2, s2;
   logic [SORT_NELEMS-1:0][p_nbits-1:0] l3, s3;

   assign vld_pipe[0] = in_val;

   // Ready chain from the output back to the input, plus per-stage data loads.
   always_comb begin
      rdy3    = !vld_pipe[3] | out_rdy;
      rdy2    = !vld_pipe[2] | rdy3;
      rdy1    = !vld_pipe[1] | rdy2;
      stg_rdy = {rdy3, rdy2, rdy1};
      dat_en  = stg_rdy & vld_pipe[SORT_NSTAGES-1:0];
   end

   // Valid bits: a stage that can load takes the upstream valid, else holds.
   for (genvar k = 1; k <= SORT_NSTAGES; k++) begin : g_vld
      tut4_verilog_sort_PipeReg #(.p_nbits(1)) u_vld (
         .clk   (clk),
         .reset (reset),
         .en    (stg_rdy[k]),
         .d     (vld_pipe[k-1]),
         .q     (vld_pipe[k])
      );
   end

   // Layer 1: (a,b) = minmax(in0,in1), (c,d) = minmax(in2,in3).
   tut4_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_mm_l1_0 (
      .in0 (in0), .in1 (in1), .out_min (l1[0]), .out_max (l1[1])
   );
   tut4_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_mm_l1_1 (
      .in0 (in2), .in1 (in3), .out_min (l1[2]), .out_max (l1[3])
   );

   tut4_verilog_sort_PipeReg #(.p_nbits(DW)) u_s1 (
      .clk (clk), .reset (reset), .en (dat_en[1]), .d (l1), .q (s1)
   );

   // Layer 2: (e,f) = minmax(a,c), (g,h) = minmax(b,d).
   tut4_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_mm_l2_0 (
      .in0 (s1[0]), .in1 (s1[2]), .out_min (l2[0]), .out_max (l2[1])
   );
   tut4_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_mm_l2_1 (
      .in0 (s1[1]), .in1 (s1[3]), .out_min (l2[2]), .out_max (l2[3])
   );

   tut4_verilog_sort_PipeReg #(.p_nbits(DW)) u_s2 (
      .clk (clk), .reset (reset), .en (dat_en[2]), .d (l2), .q (s2)
   );

   // Layer 3: (i,j) = minmax(f,g); e and h pass straight through.
   assign l3[0] = s2[0];
   assign l3[3] = s2[3];
   tut4_verilog_sort_MinMaxUnit #(.p_nbits(p_nbits)) u_mm_l3_0 (
      .in0 (s2[1]), .in1 (s2[2]), .out_min (l3[1]), .out_max (l3[2])
   );

   tut4_verilog_sort_PipeReg #(.p_nbits(DW)) u_s3 (
      .clk (clk), .reset (reset), .en (dat_en[3]), .d (l3), .q (s3)
   );

   // Output drive, masked while reset is asserted.
   always_comb begin
      in_rdy  = rdy1 | reset;
      out_val = vld_pipe[3] & !reset;
      out0    = reset ? '0 : s3[0];
      out1    = reset ? '0 : s3[1];
      out2    = reset ? '0 : s3[2];
      out3    = reset ? '0 : s3[3];
   end

endmodule

// File: tb/tb_tut4_verilog_sort_valrdy_sorter.sv
// Self-checking bench: directed steps on an 8-bit sorter, randomized
// traffic on a 16-bit sorter against a queue-based reference sort model.
module tb_tut4_verilog_sort_valrdy_sorter;

   logic clk;
   logic reset;

   // 8-bit instance
   logic       i8_val, i8_rdy, o8_val, o8_rdy;
   logic [7:0] i8_d0, i8_d1, i8_d2, i8_d3;
   logic [7:0] o8_q0, o8_q1, o8_q2, o8_q3;

   // 16-bit instance
   logic        i16_val, i16_rdy, o16_val, o16_rdy;
   logic [15:0] i16_d0, i16_d1, i16_d2, i16_d3;
   logic [15:0] o16_q0, o16_q1, o16_q2, o16_q3;

   int n_assert = 0;
   int n_fail   = 0;

   tut4_verilog_sort_valrdy_sorter #(.p_nbits(8)) u8 (
      .clk (clk), .reset (reset),
      .in_val (i8_val), .in_rdy (i8_rdy),
      .in0 (i8_d0), .in1 (i8_d1), .in2 (i8_d2), .in3 (i8_d3),
      .out_val (o8_val), .out_rdy (o8_rdy),
      .out0 (o8_q0), .out1 (o8_q1), .out2 (o8_q2), .out3 (o8_q3)
   );

   tut4_verilog_sort_valrdy_sorter #(.p_nbits(16)) u16 (
      .clk (clk), .reset (reset),
      .in_val (i16_val), .in_rdy (i16_rdy),
      .in0 (i16_d0), .in1 (i16_d1), .in2 (i16_d2), .in3 (i16_d3),
      .out_val (o16_val), .out_rdy (o16_rdy),
      .out0 (o16_q0), .out1 (o16_q1), .out2 (o16_q2), .out3 (o16_q3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] o8;
   logic [63:0] o16;
   assign o8  = {o8_q3, o8_q2, o8_q1, o8_q0};
   assign o16 = {o16_q3, o16_q2, o16_q1, o16_q0};

   // Element-0-first packing: pk(a,b,c,d) means in0=a .. in3=d.
   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   // Reference: plain ascending sort of the four 16-bit fields.
   function automatic logic [63:0] rsort(input logic [63:0] v);
      int a[4];
      int t;
      for (int i = 0; i < 4; i++) a[i] = int'(v[i*16 +: 16]);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return {a[3][15:0], a[2][15:0], a[1][15:0], a[0][15:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv8(input logic v, input logic [31:0] d, input logic ordy);
      i8_val = v;
      {i8_d3, i8_d2, i8_d1, i8_d0} = d;
      o8_rdy = ordy;
      #1;
   endtask

   logic [31:0] tv [3];
   logic [31:0] te [3];
   logic [63:0] q [$];
   logic [63:0] pend_d, exp_o;
   logic        pend;
   int          nacc, nout, cyc;

   initial begin
      reset = 1'b1;
      drv8(1'b0, '0, 1'b1);
      i16_val = 1'b0; o16_rdy = 1'b1;
      {i16_d3, i16_d2, i16_d1, i16_d0} = '0;

      // Reset state
      tick();
      chk("rst_out_val", o8_val, 0);
      chk("rst_in_rdy",  i8_rdy, 1);
      chk("rst_out",     o8, 0);
      tick();
      reset = 1'b0;
      drv8(1'b0, '0, 1'b1);
      chk("post_rst_out_val", o8_val, 0);
      chk("post_rst_in_rdy",  i8_rdy, 1);
      chk("post_rst_out",     o8, 0);

      // Single transaction: latency 3
      tick(); drv8(1'b1, pk(4,2,3,1), 1'b1);
      chk("single_in_rdy", i8_rdy, 1);
      chk("single_c0_val", o8_val, 0);
      tick(); drv8(1'b0, '0, 1'b1);
      chk("single_c1_val", o8_val, 0);
      tick();
      chk("single_c2_val", o8_val, 0);
      tick();
      chk("single_c3_val", o8_val, 1);
      chk("single_c3_out", o8, pk(1,2,3,4));
      tick();
      chk("single_c4_val", o8_val, 0);

      // Back-to-back at full throughput
      tv[0] = pk(4,3,2,1);     te[0] = pk(1,2,3,4);
      tv[1] = pk(1,1,1,1);     te[1] = pk(1,1,1,1);
      tv[2] = pk(255,0,128,7); te[2] = pk(0,7,128,255);
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k < 3) drv8(1'b1, tv[k], 1'b1);
         else       drv8(1'b0, '0, 1'b1);
         chk("b2b_in_rdy", i8_rdy, 1);
         chk("b2b_out_val", o8_val, (k >= 3) ? 1'b1 : 1'b0);
         if (k >= 3) chk("b2b_out", o8, te[k-3]);
      end
      tick(); drv8(1'b0, '0, 1'b1);
      chk("b2b_drained", o8_val, 0);

      // Back-pressure: three fill, fourth blocked, one-cycle release
      tick(); drv8(1'b1, pk(9,8,7,6), 1'b0);  chk("bp_c0_rdy", i8_rdy, 1);
      tick(); drv8(1'b1, pk(1,5,3,2), 1'b0);  chk("bp_c1_rdy", i8_rdy, 1);
      tick(); drv8(1'b1, pk(200,100,50,25), 1'b0); chk("bp_c2_rdy", i8_rdy, 1);
      tick(); drv8(1'b1, pk(3,3,0,9), 1'b0);
      chk("bp_full_rdy", i8_rdy, 0);
      chk("bp_full_val", o8_val, 1);
      chk("bp_full_out", o8, pk(6,7,8,9));
      tick(); drv8(1'b1, pk(3,3,0,9), 1'b0);
      chk("bp_hold_rdy", i8_rdy, 0);
      chk("bp_hold_out", o8, pk(6,7,8,9));
      tick(); drv8(1'b1, pk(3,3,0,9), 1'b1);
      chk("bp_rel_in_rdy", i8_rdy, 1);
      chk("bp_rel_val", o8_val, 1);
      chk("bp_rel_out", o8, pk(6,7,8,9));
      tick(); drv8(1'b0, '0, 1'b0);
      chk("bp_refull_rdy", i8_rdy, 0);
      chk("bp_second_out", o8, pk(1,2,3,5));
      tick(); drv8(1'b0, '0, 1'b1);
      chk("bp_drain0", o8, pk(1,2,3,5));
      tick(); chk("bp_drain1", o8, pk(25,50,100,200));
      tick(); chk("bp_drain2", o8, pk(0,3,3,9));
      tick(); chk("bp_empty", o8_val, 0);

      // Bubble collapse under a stalled output
      tick(); drv8(1'b1, pk(40,30,20,10), 1'b0); chk("bub_c0_rdy", i8_rdy, 1);
      tick(); drv8(1'b0, '0, 1'b0);
      tick(); drv8(1'b1, pk(2,9,2,9), 1'b0);     chk("bub_c2_rdy", i8_rdy, 1);
      for (int k = 3; k < 6; k++) begin
         tick(); drv8(1'b0, '0, 1'b0);
         chk("bub_hold_val", o8_val, 1);
         chk("bub_hold_out", o8, pk(10,20,30,40));
      end
      tick(); drv8(1'b0, '0, 1'b1);
      chk("bub_c6_out", o8, pk(10,20,30,40));
      tick(); chk("bub_c7_val", o8_val, 1);
      chk("bub_c7_out", o8, pk(2,2,9,9));
      tick(); chk("bub_c8_val", o8_val, 0);

      // Reset mid-flight discards in-flight work
      tick(); drv8(1'b1, pk(5,6,7,8), 1'b1);
      tick(); drv8(1'b1, pk(8,7,6,5), 1'b1);
      tick(); reset = 1'b1; drv8(1'b0, '0, 1'b1);
      chk("midrst_val", o8_val, 0);
      chk("midrst_in_rdy", i8_rdy, 1);
      chk("midrst_out", o8, 0);
      for (int k = 0; k < 5; k++) begin
         tick(); reset = 1'b0; drv8(1'b0, '0, 1'b1);
         chk("afterrst_val", o8_val, 0);
         chk("afterrst_in_rdy", i8_rdy, 1);
      end

      // Random traffic on the 16-bit instance
      pend = 1'b0; pend_d = '0; nacc = 0; nout = 0; cyc = 0;
      while ((nacc < 1000 || q.size() != 0) && cyc < 20000) begin
         tick();
         cyc++;
         if (!pend && nacc < 1000 && ($urandom % 4) != 0) begin
            pend   = 1'b1;
            pend_d = {$urandom, $urandom};
         end
         i16_val = pend;
         {i16_d3, i16_d2, i16_d1, i16_d0} = pend_d;
         o16_rdy = ($urandom % 3) != 0;
         #1;
         chk("rnd_in_rdy", i16_rdy, (q.size() < 3) ? 1'b1 : o16_rdy);
         if (q.size() == 3) chk("rnd_full_val", o16_val, 1);
         if (o16_val) begin
            chk("rnd_val_nonempty", (q.size() != 0), 1);
            if (o16_rdy && q.size() != 0) begin
               exp_o = q.pop_front();
               chk("rnd_out", o16, exp_o);
               nout++;
            end
         end
         if (i16_val && i16_rdy) begin
            q.push_back(rsort(pend_d));
            pend = 1'b0;
            nacc++;
         end
      end
      i16_val = 1'b0;
      chk("rnd_accepted", nacc, 1000);
      chk("rnd_emitted", nout, 1000);
      chk("rnd_queue_empty", q.size(), 0);
      tick();
      chk("rnd_idle_val", o16_val, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
